// File: rtl/aes_sbox_fwd_seq.sv
// Sequential forward AES S-box: x^254 in GF(2^8) by MSB-first square-and-multiply
// on one shared multiplier, followed by the forward affine transform.
module aes_sbox_fwd_seq #(
    parameter bit AFFINE_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] x,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] y,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQ   = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [7:0] EXP   = 8'hFE;
    localparam logic [7:0] AFF_C = 8'h63;

    state_t     state_reg;
    logic [7:0] x_reg;
    logic [7:0] r_reg;
    logic [7:0] y_reg;
    logic [2:0] idx_reg;
    logic       in_ready_reg;
    logic       out_valid_reg;
    logic       busy_reg;

    logic [7:0] mul_b;
    logic [7:0] prod;
    logic [7:0] aff;
    logic [7:0] result;

    // Carry-less product reduced modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1B : 8'h00);
        end
        return acc;
    endfunction

    // The single multiplier squares in SQ and multiplies by the captured byte in MUL.
    assign mul_b = (state_reg == MUL) ? x_reg : r_reg;
    assign prod  = gf_mul(r_reg, mul_b);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_aff
            assign aff[gi] = prod[gi] ^ prod[(gi + 4) % 8] ^ prod[(gi + 5) % 8]
                           ^ prod[(gi + 6) % 8] ^ prod[(gi + 7) % 8] ^ AFF_C[gi];
        end
    endgenerate

    assign result = AFFINE_EN ? aff : prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            x_reg         <= 8'h00;
            r_reg         <= 8'h01;
            y_reg         <= 8'h00;
            idx_reg       <= 3'd7;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready_reg) begin
                        x_reg        <= x;
                        r_reg        <= 8'h01;
                        idx_reg      <= 3'd7;
                        state_reg    <= SQ;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                end
                SQ: begin
                    r_reg <= prod;
                    if (EXP[idx_reg]) begin
                        state_reg <= MUL;
                    end else if (idx_reg == 3'd0) begin
                        state_reg     <= DONE;
                        y_reg         <= result;
                        out_valid_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                    end else begin
                        // Zero exponent bit above bit 0: square only, move on.
                        idx_reg <= idx_reg - 3'd1;
                    end
                end
                MUL: begin
                    r_reg     <= prod;
                    idx_reg   <= idx_reg - 3'd1;
                    state_reg <= SQ;
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign y         = y_reg;

endmodule
